sisc_ifetch: RTL and testbench

- Instruction fetch unit for the SISC processor; it is the instruction-side counterpart of the control FSM.
- Owns the PC and the instruction register (IR).
- Reads instruction memory through a req/ack handshake and presents the decoded IR fields (opcode, mm, register addresses, immediate) to the control FSM and register file.
- Executes PC redirection for BRA/BRR/BNE when the control FSM requests it.

---
 rtl/sisc_ifetch.sv | 175 +++++++++++++++++
 tb/tb_sisc_ifetch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_ifetch.sv
// SISC instruction fetch unit: owns PC and IR, fetches through a req/ack
// handshake, decodes IR fields and applies BRA/BRR/BNE redirection.
//
// state | meaning
// IDLE  | no instruction held yet, waiting for fetch_req
// REQ   | read outstanding on imem, waiting for imem_ack
// HOLD  | IR holds an instruction; branch evaluation or next fetch allowed
module sisc_ifetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              br_req,
    input  logic [3:0]        stat,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              imem_ack,
    output logic              ir_valid,
    output logic              busy,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic [3:0]        rd_addr,
    output logic [3:0]        rs_addr,
    output logic [3:0]        rt_addr,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc,
    output logic              br_taken,
    output logic              halted
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    localparam logic [3:0] OP_BRA = 4'd4;
    localparam logic [3:0] OP_BRR = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_HLT = 4'd15;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              valid_q, valid_d;
    logic              rd_q, rd_d;
    logic              taken_q, taken_d;
    logic              halted_q, halted_d;
    logic              pend_q, pend_d;

    logic              cond;
    logic              br_hit;
    logic [ADDR_W-1:0] br_target;
    logic              issue;

    // Branch condition and target, evaluated against the already-incremented PC.
    always_comb begin
        cond      = |(ir_q[27:24] & stat);
        br_hit    = 1'b0;
        br_target = pc_q;
        case (ir_q[31:28])
            OP_BRA: begin
                br_hit    = (ir_q[27:24] == 4'd0) || cond;
                br_target = ADDR_W'(ir_q[15:0]);
            end
            OP_BRR: begin
                br_hit    = (ir_q[27:24] == 4'd0) || cond;
                br_target = pc_q + ADDR_W'($signed(ir_q[15:0]));
            end
            OP_BNE: begin
                br_hit    = !cond;
                br_target = ADDR_W'(ir_q[15:0]);
            end
            default: begin
                br_hit    = 1'b0;
                br_target = pc_q;
            end
        endcase
    end

    // Next-state logic: fetch handshake, branch redirect, deferred fetch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        rd_d     = rd_q;
        taken_d  = 1'b0;
        halted_d = halted_q;
        pend_d   = pend_q;
        issue    = 1'b0;
        case (state_q)
            S_IDLE: begin
                issue = fetch_req && !halted_q;
            end
            S_REQ: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    valid_d = 1'b1;
                    rd_d    = 1'b0;
                    state_d = S_HOLD;
                    if (imem_data[31:28] == OP_HLT) begin
                        halted_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (pend_q) begin
                    issue = 1'b1;
                end else if (br_req) begin
                    if (br_hit) begin
                        pc_d    = br_target;
                        taken_d = 1'b1;
                    end
                    // a fetch requested alongside the branch waits for the new PC
                    pend_d = fetch_req && !halted_q;
                end else begin
                    issue = fetch_req && !halted_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (issue) begin
            state_d = S_REQ;
            rd_d    = 1'b1;
            addr_d  = pc_q;
            pend_d  = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            rd_q     <= 1'b0;
            taken_q  <= 1'b0;
            halted_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            rd_q     <= rd_d;
            taken_q  <= taken_d;
            halted_q <= halted_d;
            pend_q   <= pend_d;
        end
    end

    assign imem_rd   = rd_q;
    assign imem_addr = addr_q;
    assign busy      = rd_q;
    assign ir_valid  = valid_q;
    assign pc        = pc_q;
    assign br_taken  = taken_q;
    assign halted    = halted_q;
    assign opcode    = ir_q[31:28];
    assign mm        = ir_q[27:24];
    assign rd_addr   = ir_q[23:20];
    assign rs_addr   = ir_q[19:16];
    assign rt_addr   = ir_q[15:12];
    assign imm       = ir_q[15:0];

endmodule

// File: tb/tb_sisc_ifetch.sv
// Bench for sisc_ifetch: scripted scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the fetch unit.
module tb_sisc_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        br_req;
    logic [3:0]  stat;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ack;
    logic        ir_valid;
    logic        busy;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [3:0]  rd_addr;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        br_taken;
    logic        halted;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: what the unit should hold, in transaction terms
    logic [15:0] m_pc;
    logic [31:0] m_ir;
    logic [15:0] m_addr;
    bit          m_valid;
    bit          m_fetching;
    bit          m_halted;
    bit          m_pend;
    bit          m_taken;

    sisc_ifetch #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .br_req    (br_req),
        .stat      (stat),
        .imem_rd   (imem_rd),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .imem_ack  (imem_ack),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .opcode    (opcode),
        .mm        (mm),
        .rd_addr   (rd_addr),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .imm       (imm),
        .pc        (pc),
        .br_taken  (br_taken),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the branch rules to the held instruction.
    task automatic model_branch();
        int op, cm, tgt;
        bit c, take;
        op   = int'(m_ir[31:28]);
        cm   = int'(m_ir[27:24]);
        c    = (m_ir[27:24] & stat) != 4'd0;
        take = 1'b0;
        tgt  = 0;
        if (op == 4 && (cm == 0 || c)) begin
            take = 1'b1;
            tgt  = int'(m_ir[15:0]);
        end else if (op == 5 && (cm == 0 || c)) begin
            take = 1'b1;
            tgt  = (int'(m_pc) + int'($signed(m_ir[15:0]))) % 65536;
            if (tgt < 0) tgt += 65536;
        end else if (op == 6 && !c) begin
            take = 1'b1;
            tgt  = int'(m_ir[15:0]);
        end
        if (take) begin
            m_pc    = 16'(tgt);
            m_taken = 1'b1;
        end
    endtask

    // Advance the model by one clock edge using the inputs presented at it.
    task automatic model_edge();
        bit go;
        m_taken = 1'b0;
        go      = 1'b0;
        if (rst) begin
            m_pc = 16'h0000; m_ir = '0; m_addr = '0;
            m_valid = 0; m_fetching = 0; m_halted = 0; m_pend = 0;
        end else if (m_fetching) begin
            if (imem_ack) begin
                m_ir       = imem_data;
                m_pc       = m_pc + 16'd1;
                m_valid    = 1'b1;
                m_fetching = 1'b0;
                if (imem_data[31:28] == 4'hF) m_halted = 1'b1;
            end
        end else begin
            if (m_valid && m_pend) begin
                go = 1'b1;
            end else if (m_valid && br_req) begin
                model_branch();
                m_pend = fetch_req && !m_halted;
            end else if (fetch_req && !m_halted) begin
                go = 1'b1;
            end
            if (go) begin
                m_fetching = 1'b1;
                m_addr     = m_pc;
                m_pend     = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_rd", 32'(imem_rd), 32'(m_fetching));
        if (m_fetching) chk("imem_addr", 32'(imem_addr), 32'(m_addr));
        chk("busy", 32'(busy), 32'(m_fetching));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("ir", {opcode, mm, rd_addr, rs_addr, imm}, m_ir);
        chk("rt_addr", 32'(rt_addr), 32'(m_ir[15:12]));
        chk("ir_valid", 32'(ir_valid), 32'(m_valid));
        chk("br_taken", 32'(br_taken), 32'(m_taken));
        chk("halted", 32'(halted), 32'(m_halted));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic fetch(input logic [31:0] d, input int wait_n);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        repeat (wait_n) tick();
        imem_ack  = 1'b1;
        imem_data = d;
        tick();
        imem_ack  = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] d;
        int sel;
        d   = $urandom;
        sel = $urandom_range(0, 19);
        if (sel < 12)       d[31:28] = 4'(4 + sel % 3);
        else if (sel == 19) d[31:28] = 4'hF;
        else                d[31:28] = 4'(sel - 12);
        if ($urandom_range(0, 1) == 1) d[27:24] = 4'd0;
        return d;
    endfunction

    initial begin
        rst = 1'b1; fetch_req = 0; br_req = 0; stat = 0; imem_ack = 0; imem_data = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_valid", 32'(ir_valid), 32'h0);

        // zero-wait fetch and field decode
        fetch(32'h1812_3000, 0);
        chk("dec_opcode", 32'(opcode), 32'd1);
        chk("dec_mm", 32'(mm), 32'd8);
        chk("dec_rd", 32'(rd_addr), 32'd1);
        chk("dec_rs", 32'(rs_addr), 32'd2);
        chk("dec_rt", 32'(rt_addr), 32'd3);
        chk("dec_pc", 32'(pc), 32'd1);

        // three-cycle wait, stray fetch_req mid-wait
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        chk("wait_rd", 32'(imem_rd), 32'd1);
        chk("wait_addr", 32'(imem_addr), 32'd1);
        imem_ack = 1'b1; imem_data = 32'h0;
        tick();
        imem_ack = 1'b0;
        chk("wait_done_rd", 32'(imem_rd), 32'd0);

        fetch(32'h0, 0);
        fetch(32'h0, 1);
        fetch(32'h5000_FFFE, 0);
        chk("brr_pre_pc", 32'(pc), 32'd5);
        br_req = 1'b1;
        tick();
        br_req = 1'b0;
        chk("brr_pc", 32'(pc), 32'd3);
        chk("brr_taken", 32'(br_taken), 32'd1);
        tick();
        chk("brr_pulse", 32'(br_taken), 32'd0);

        fetch(32'h6100_0080, 0);
        stat = 4'b0001; br_req = 1'b1;
        tick();
        br_req = 1'b0; stat = 4'b0000;
        chk("bne_pc", 32'(pc), 32'd4);
        chk("bne_taken", 32'(br_taken), 32'd0);

        // branch and fetch together
        fetch(32'h4000_0040, 0);
        fetch_req = 1'b1; br_req = 1'b1;
        tick();
        fetch_req = 1'b0; br_req = 1'b0;
        chk("combo_pc", 32'(pc), 32'h40);
        tick();
        chk("combo_rd", 32'(imem_rd), 32'd1);
        chk("combo_addr", 32'(imem_addr), 32'h40);
        imem_ack = 1'b1; imem_data = 32'h0;
        tick();
        imem_ack = 1'b0;

        // PC wrap then halt
        fetch(32'h4000_FFFF, 0);
        br_req = 1'b1;
        tick();
        br_req = 1'b0;
        chk("wrap_pre", 32'(pc), 32'hFFFF);
        fetch(32'h0, 0);
        chk("wrap_pc", 32'(pc), 32'h0);
        fetch(32'hF000_0000, 2);
        chk("hlt_halted", 32'(halted), 32'd1);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("hlt_no_rd", 32'(imem_rd), 32'd0);

        // reset while a read is outstanding, late ack ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; imem_ack = 1'b1; imem_data = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        chk("rstreq_rd", 32'(imem_rd), 32'd0);
        chk("rstreq_ir", {opcode, mm, rd_addr, rs_addr, imm}, 32'h0);
        chk("rstreq_valid", 32'(ir_valid), 32'd0);
        chk("rstreq_pc", 32'(pc), 32'd0);
        tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 9) == 0);
            fetch_req = ($urandom_range(0, 3) == 0);
            br_req    = ($urandom_range(0, 2) == 0);
            stat      = 4'($urandom);
            imem_ack  = m_fetching ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            imem_data = rand_instr();
            tick();
        end
        rst = 0; fetch_req = 0; br_req = 0; imem_ack = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
